dcache_nway: RTL
================

Name: dcache_nway

Overview:
- Parametrised write-back, write-allocate data cache sitting between the datapath memory port and the memory/bus arbiter.
- Generalises the 2-way, 2-word dcache to N ways, M words per block and any power-of-two set count.
- Replacement is true LRU, using per-way age counters.
- Adds a halt sequence: full dirty-block flush, then a hit-count write to memory, then the `flushed` indication.

Parameters:
- NUM_SETS, 8, number of sets (power of two, ≥2)
- WAYS, 4, associativity (power of two, ≥2)
- WORDS_PER_BLOCK, 2, 32-bit words per block (power of two, ≥2)
- ADDR_W, 32, address width
- HIT_COUNT_ADDR, 32'h3100, memory address receiving hit_count at halt

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low
- dmemREN  in  1  datapath read request
- dmemWEN  in  1  datapath write request (mutually exclusive with dmemREN)
- dmemaddr  in  ADDR_W  byte address, word aligned
- dmemstore  in  32  write data
- halt  in  1  datapath halted; request flush
- dhit  out  1  request serviced this cycle
- dmemload  out  32  read data, valid when dhit & dmemREN
- flushed  out  1  flush + count complete
- dREN  out  1  memory read
- dWEN  out  1  memory write
- daddr  out  ADDR_W  memory word address
- dstore  out  32  memory write data
- dwait  in  1  memory busy; a word transfers on a cycle with dREN|dWEN and !dwait
- dload  in  32  memory read data

Behaviour:
- Address split, LSB up: byteoff[1:0], blkoff clog2(WORDS_PER_BLOCK), idx clog2(NUM_SETS), tag = remainder.
- Per frame: valid, dirty, tag, data[WORDS_PER_BLOCK]. Per set: age[WAYS], each clog2(WAYS) bits.

Reset (async, any state):
- All valid/dirty bits = 0; state = IDLE; counters = 0; hit_count = 0.
- age[w] = w.
- All outputs = 0.

States:
- IDLE:
  - halt has priority over requests: go to FLUSH_SCAN.
  - Else on REN|WEN, hit = valid & tag match on any way (lowest way wins if duplicated).
  - On a hit:
    - dhit = 1 combinationally in the same cycle; dmemload = word.
    - A write stores dmemstore and sets dirty at the next edge.
    - hit_count += 1.
    - LRU update: hit way age → 0; every way with age < old age increments.
  - On a miss:
    - Latch victim_way: the lowest-index invalid way, else the way with age == WAYS-1.
    - hit_count -= 1, so the replayed hit after refill nets zero.
    - word_cnt = 0.
    - Next state is WB if the victim is valid & dirty, else LOAD.
- WB:
  - dWEN = 1; daddr = {victim.tag, idx, word_cnt, 2'b00}; dstore = victim.data[word_cnt].
  - On !dwait: word_cnt++.
  - The last word clears victim dirty/valid, resets word_cnt and goes to LOAD.
- LOAD:
  - dREN = 1; daddr = {req.tag, idx, word_cnt, 2'b00}.
  - On !dwait: data[word_cnt] = dload; word_cnt++.
  - The last word sets tag, valid = 1, dirty = 0 and goes to IDLE.
  - The request is then serviced as a hit on the following cycle.
- FLUSH_SCAN:
  - Walks flush_ptr from 0 to NUM_SETS*WAYS-1; set = flush_ptr / WAYS, way = flush_ptr % WAYS.
  - If the frame is valid & dirty, go to FLUSH_WB; else flush_ptr++ (one frame per cycle).
  - After the final frame, go to COUNT.
- FLUSH_WB:
  - Same word burst as WB, using that frame.
  - The last word clears dirty/valid, flush_ptr++, and returns to FLUSH_SCAN.
- COUNT:
  - dWEN = 1; daddr = HIT_COUNT_ADDR; dstore = hit_count.
  - On !dwait, go to HALTED.
- HALTED: flushed = 1; terminal until reset; dhit = 0.

Boundary rules:
- dhit = 0 in every state except IDLE.
- Requests held during a miss are ignored until IDLE.
- The request must remain stable through the refill.
- halt raised mid-miss: the refill completes first; the flush starts in the next IDLE cycle.
- dwait may stay high indefinitely; address/data held stable.
- hit_count is 32-bit two's complement and wraps.
- Victim selection and word_cnt are registered, never recomputed mid-burst.
- dREN and dWEN are never both 1.

Test Plan:
- Defaults used (NUM_SETS=8, WAYS=4, WORDS_PER_BLOCK=2).
1. Cold read of 0x100, mem[0x100]=0x11, mem[0x104]=0x22 → LOAD reads 0x100 then 0x104; next cycle dhit=1, dmemload=0x11; read 0x104 → same-cycle dhit, 0x22.
2. Write 0x104 ← 0xDEADBEEF after scenario 1, then read 0x104 → dhit both cycles, dmemload=0xDEADBEEF, no memory traffic.
3. Write 0x000, then read 0x040, 0x080, 0x0C0, 0x100 (all set 0) → the fifth access writes back 0x000/0x004 (dirty data) before loading 0x100.
4. LRU: fill set 0 with A=0x000, B=0x040, C=0x080, D=0x0C0; re-read A; read E=0x100 → B is evicted; A, C, D still hit.
5. Two dirty blocks present, assert halt → exactly four dWEN word writes, then a dWEN to 0x3100 with the net hit_count; flushed=1 held.
6. dwait high 3 cycles per word during LOAD; assert nRST low mid-burst → all outputs 0 immediately; a subsequent read of the same address misses.

Source files
------------

// File: rtl/dcache_nway.sv
// N-way, M-word write-back / write-allocate data cache with true-LRU ages.
// Halt flushes every dirty frame, then writes the net hit count to memory.
module dcache_nway #(
  parameter int          NUM_SETS        = 8,
  parameter int          WAYS            = 4,
  parameter int          WORDS_PER_BLOCK = 2,
  parameter int          ADDR_W          = 32,
  parameter logic [31:0] HIT_COUNT_ADDR  = 32'h3100
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [31:0]       dmemstore,
  input  logic              halt,
  output logic              dhit,
  output logic [31:0]       dmemload,
  output logic              flushed,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] daddr,
  output logic [31:0]       dstore,
  input  logic              dwait,
  input  logic [31:0]       dload
);

  localparam int BW = $clog2(WORDS_PER_BLOCK);
  localparam int IW = $clog2(NUM_SETS);
  localparam int AW = $clog2(WAYS);
  localparam int TW = ADDR_W - 2 - BW - IW;
  localparam int PW = IW + AW;

  typedef enum logic [2:0] {
    IDLE, WB, LOAD, FLUSH_SCAN, FLUSH_WB, COUNT, HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     wcnt_q, wcnt_d;
  logic [AW-1:0]     victim_q, victim_d;
  logic [PW:0]       fptr_q, fptr_d;
  logic [31:0]       hcnt_q, hcnt_d;

  logic              valid_q [NUM_SETS][WAYS];
  logic              valid_d [NUM_SETS][WAYS];
  logic              dirty_q [NUM_SETS][WAYS];
  logic              dirty_d [NUM_SETS][WAYS];
  logic [TW-1:0]     tag_q   [NUM_SETS][WAYS];
  logic [TW-1:0]     tag_d   [NUM_SETS][WAYS];
  logic [AW-1:0]     age_q   [NUM_SETS][WAYS];
  logic [AW-1:0]     age_d   [NUM_SETS][WAYS];
  logic [31:0]       data_q  [NUM_SETS][WAYS][WORDS_PER_BLOCK];
  logic [31:0]       data_d  [NUM_SETS][WAYS][WORDS_PER_BLOCK];

  logic              req;
  logic [BW-1:0]     req_blk;
  logic [IW-1:0]     req_idx;
  logic [TW-1:0]     req_tag;
  logic              hit;
  logic [AW-1:0]     hit_way;
  logic [AW-1:0]     vic_way;
  logic [AW-1:0]     lru_way;
  logic [AW-1:0]     inv_way;
  logic              inv_any;
  logic [IW-1:0]     fset;
  logic [AW-1:0]     fway;
  logic [IW-1:0]     b_set;
  logic [AW-1:0]     b_way;
  logic              b_last;
  logic              unused_ok;

  assign req       = dmemREN | dmemWEN;
  assign req_blk   = dmemaddr[BW+1:2];
  assign req_idx   = dmemaddr[IW+BW+1:BW+2];
  assign req_tag   = dmemaddr[ADDR_W-1:ADDR_W-TW];
  assign unused_ok = ^dmemaddr[1:0];

  assign fset   = fptr_q[PW-1:AW];
  assign fway   = fptr_q[AW-1:0];
  assign b_set  = (state_q == FLUSH_WB) ? fset : req_idx;
  assign b_way  = (state_q == FLUSH_WB) ? fway : victim_q;
  assign b_last = (wcnt_q == BW'(WORDS_PER_BLOCK - 1));

  // Tag lookup and victim choice; downward loops make the lowest way win.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    lru_way = '0;
    inv_way = '0;
    inv_any = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][AW'(w)] &&
          tag_q[req_idx][AW'(w)] == req_tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
      if (age_q[req_idx][AW'(w)] == AW'(WAYS - 1))
        lru_way = AW'(w);
      if (!valid_q[req_idx][AW'(w)]) begin
        inv_any = 1'b1;
        inv_way = AW'(w);
      end
    end
    vic_way = inv_any ? inv_way : lru_way;
  end

  // Datapath and memory-side outputs decoded from the current state.
  always_comb begin
    dhit     = 1'b0;
    dmemload = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    flushed  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!halt && req && hit) begin
          dhit = 1'b1;
          if (dmemREN)
            dmemload = data_q[req_idx][hit_way][req_blk];
        end
      end
      WB, FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[b_set][b_way], b_set, wcnt_q, 2'b00};
        dstore = data_q[b_set][b_way][wcnt_q];
      end
      LOAD: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, wcnt_q, 2'b00};
      end
      COUNT: begin
        dWEN   = 1'b1;
        daddr  = ADDR_W'(HIT_COUNT_ADDR);
        dstore = hcnt_q;
      end
      HALTED: flushed = 1'b1;
      default: ;
    endcase
  end

  // Next-state: hit service, miss refill bursts and the halt flush walk.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    victim_d = victim_q;
    fptr_d   = fptr_q;
    hcnt_d   = hcnt_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    tag_d    = tag_q;
    age_d    = age_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = FLUSH_SCAN;
          fptr_d  = '0;
        end else if (req && hit) begin
          hcnt_d = hcnt_q + 32'd1;
          if (dmemWEN) begin
            data_d[req_idx][hit_way][req_blk] = dmemstore;
            dirty_d[req_idx][hit_way]         = 1'b1;
          end
          for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == hit_way)
              age_d[req_idx][AW'(w)] = '0;
            else if (age_q[req_idx][AW'(w)] <
                     age_q[req_idx][hit_way])
              age_d[req_idx][AW'(w)] =
                age_q[req_idx][AW'(w)] + AW'(1);
          end
        end else if (req) begin
          victim_d = vic_way;
          hcnt_d   = hcnt_q - 32'd1;
          wcnt_d   = '0;
          state_d  = (valid_q[req_idx][vic_way] &&
                      dirty_q[req_idx][vic_way]) ? WB : LOAD;
        end
      end
      WB, FLUSH_WB: begin
        if (!dwait) begin
          if (b_last) begin
            valid_d[b_set][b_way] = 1'b0;
            dirty_d[b_set][b_way] = 1'b0;
            wcnt_d                = '0;
            if (state_q == WB) begin
              state_d = LOAD;
            end else begin
              fptr_d  = fptr_q + (PW+1)'(1);
              state_d = FLUSH_SCAN;
            end
          end else begin
            wcnt_d = wcnt_q + BW'(1);
          end
        end
      end
      LOAD: begin
        if (!dwait) begin
          data_d[req_idx][victim_q][wcnt_q] = dload;
          if (b_last) begin
            tag_d[req_idx][victim_q]   = req_tag;
            valid_d[req_idx][victim_q] = 1'b1;
            dirty_d[req_idx][victim_q] = 1'b0;
            wcnt_d                     = '0;
            state_d                    = IDLE;
          end else begin
            wcnt_d = wcnt_q + BW'(1);
          end
        end
      end
      FLUSH_SCAN: begin
        if (fptr_q[PW]) begin
          state_d = COUNT;
        end else if (valid_q[fset][fway] && dirty_q[fset][fway]) begin
          wcnt_d  = '0;
          state_d = FLUSH_WB;
        end else begin
          fptr_d = fptr_q + (PW+1)'(1);
        end
      end
      COUNT: begin
        if (!dwait)
          state_d = HALTED;
      end
      HALTED: ;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and frame storage; ages restart as a permutation.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      victim_q <= '0;
      fptr_q   <= '0;
      hcnt_q   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= AW'(w);
          for (int m = 0; m < WORDS_PER_BLOCK; m++)
            data_q[s][w][m] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      victim_q <= victim_d;
      fptr_q   <= fptr_d;
      hcnt_q   <= hcnt_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      tag_q    <= tag_d;
      age_q    <= age_d;
      data_q   <= data_d;
    end
  end

endmodule
